shift_left_iter: RTL

SHIFT_LEFT_ITER -- requirements
Module: shift_left_iter

---
 rtl/shift_left_iter_if.sv | 32 +++
 rtl/shift_left_iter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/shift_left_iter_if.sv
// ---------------------------------------------------------------------------
// shift_left_iter_if
// Request/response bundle for the iterative left shifter.
//   start    : request, accepted only on an edge where ready=1
//   data     : operand, sampled on the accepting edge
//   shiftamt : left-shift count, sampled on the accepting edge
//   ready    : high while the shifter is idle
//   done     : one-cycle completion pulse; result is valid while it is high
//   result   : registered result, held until the next completion
// The master modport is the requester; the slave modport is the shifter.
// ---------------------------------------------------------------------------
interface shift_left_iter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [AMT_W-1:0] shiftamt;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, data, shiftamt,
    input  ready, done, result
  );

  modport slave (
    input  start, data, shiftamt,
    output ready, done, result
  );
endinterface

// File: rtl/shift_left_iter.sv
// ---------------------------------------------------------------------------
// shift_left_iter
// Logical left shifter that works through the shift amount one bit per clock:
// stage k shifts the working value left by 2^k when shiftamt[k] is set.
//
// Ports:
//   clock : sole clock, rising edge
//   reset : synchronous, active-high; returns to IDLE and clears all state
//   bus   : shift_left_iter_if.slave (start/data/shiftamt in,
//           ready/done/result out)
//
// Parameters:
//   WIDTH : datapath width, power of two, >= 2
//   AMT_W : shift-amount width, log2(WIDTH)
//
// Build option:
//   SHIFT_LEFT_ITER_EARLY_DONE_EN : when defined, finish as soon as no set
//   shift-amount bit remains above the current stage. Results, handshake and
//   reset behaviour are unchanged; only the latency shrinks.
// ---------------------------------------------------------------------------
module shift_left_iter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  shift_left_iter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] work_q;      // value being shifted
  logic [WIDTH-1:0] result_q;    // last completed result
  logic [AMT_W-1:0] amt_q;       // shift amount latched at accept
  logic [AMT_W-1:0] k_q;         // stage index, 0..AMT_W-1 (fits in AMT_W bits)

  logic [WIDTH-1:0] shift_dist;  // 2^k
  logic [WIDTH-1:0] stage_val;   // working value after processing stage k
  logic             stage_bit;   // latched shiftamt[k]
  logic             last_stage;
  logic             finish;      // this SHIFT edge completes the operation

  // -------------------------------------------------------------------------
  // Stage datapath and next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    shift_dist = WIDTH'(1) << k_q;
    // Mask test instead of amt_q[k_q] keeps the select width-exact.
    stage_bit  = |(amt_q & (AMT_W'(1) << k_q));
    stage_val  = stage_bit ? (work_q << shift_dist) : work_q;
    last_stage = (k_q == AMT_W'(AMT_W - 1));
`ifdef SHIFT_LEFT_ITER_EARLY_DONE_EN
    // Nothing left to shift once every amount bit above k is zero.
    finish     = last_stage || (((amt_q >> k_q) >> 1) == '0);
`else
    finish     = last_stage;
`endif

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (finish)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: every datapath register is reset here, including result, because
  // reset must leave a visible result of zero, not merely an idle FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      work_q   <= '0;
      result_q <= '0;
      amt_q    <= '0;
      k_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            work_q <= bus.data;
            amt_q  <= bus.shiftamt;
            k_q    <= '0;
          end
        end
        SHIFT: begin
          work_q <= stage_val;
          k_q    <= k_q + AMT_W'(1);
          if (finish) result_q <= stage_val;
        end
        default: ;  // DONE: hold everything; starts are ignored
      endcase
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule
